// File: rtl/rv32i_types.sv
// Shared types and default sizes for the cache-line burst adaptor.
package rv32i_types;

    localparam int ADDR_W_DEF  = 32;
    localparam int LINE_W_DEF  = 256;
    localparam int BURST_W_DEF = 64;
    localparam int STAT_W_DEF  = 16;
    localparam int BEATS_DEF   = LINE_W_DEF / BURST_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP
    } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor_buffer.sv
// line_beat_buffer: one cache line of storage, filled either whole or one beat
// at a time, with a beat-indexed read port.
module line_beat_buffer #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [LINE_W-1:0]    line_i,
    input  logic                 beat_we_i,
    input  logic [((LINE_W/BURST_W) > 1 ? $clog2(LINE_W/BURST_W) : 1)-1:0] beat_idx_i,
    input  logic [BURST_W-1:0]   beat_data_i,
    output logic [LINE_W-1:0]    line_o,
    output logic [BURST_W-1:0]   beat_o
);

    logic [LINE_W-1:0] buf_q;

    // A full-line load takes priority over a single-beat write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (load_i) begin
            buf_q <= line_i;
        end else if (beat_we_i) begin
            buf_q[int'(beat_idx_i) * BURST_W +: BURST_W] <= beat_data_i;
        end
    end

    assign line_o = buf_q;
    assign beat_o = buf_q[int'(beat_idx_i) * BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one full-line pmem read/write into a fixed-length beat burst.
// Optional statistics counters are built when CACHELINE_ADAPTOR_STATS_EN is defined.
module cacheline_adaptor
    import rv32i_types::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int BURST_W = BURST_W_DEF,
    parameter int STAT_W  = STAT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [ADDR_W-1:0]  pmem_address,
    input  logic [LINE_W-1:0]  pmem_wdata,
    output logic [LINE_W-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic               burst_read,
    output logic               burst_write,
    output logic [ADDR_W-1:0]  burst_addr,
    output logic [BURST_W-1:0] burst_wdata,
    input  logic [BURST_W-1:0] burst_rdata,
    input  logic               burst_resp,
    output logic [STAT_W-1:0]  stat_reads,
    output logic [STAT_W-1:0]  stat_writes
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(LINE_W / 8);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    adaptor_state_e     state_q;
    logic [BW-1:0]      beat_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               rd_q, wr_q, resp_q;

    logic               lastAccept;
    logic               rdFill;
    logic               wrLoad;
    logic [BURST_W-1:0] wrBeat;
    logic [BURST_W-1:0] unusedRdBeat;
    logic [LINE_W-1:0]  unusedWrLine;
    logic               unusedAddrBits;

    assign lastAccept     = burst_resp && (beat_q == LAST_BEAT);
    assign rdFill         = (state_q == RD_BURST) && burst_resp;
    assign wrLoad         = (state_q == IDLE) && !pmem_read && pmem_write;
    assign unusedAddrBits = ^pmem_address[OFF-1:0];

    // Burst strobes and the response pulse are flopped alongside the state so
    // they change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        addr_q <= {pmem_address[ADDR_W-1:OFF], {OFF{1'b0}}};
                    end
                    if (pmem_read) begin
                        state_q <= RD_BURST;
                        rd_q    <= 1'b1;
                    end else if (pmem_write) begin
                        state_q <= WR_BURST;
                        wr_q    <= 1'b1;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (lastAccept) begin
                        state_q <= RESP;
                        beat_q  <= '0;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        resp_q  <= 1'b1;
                    end else if (burst_resp) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    beat_q  <= '0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    resp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Separate read and write buffers so pmem_rdata survives intervening writes.
    line_beat_buffer #(.LINE_W(LINE_W), .BURST_W(BURST_W)) u_rd_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .line_i      ({LINE_W{1'b0}}),
        .beat_we_i   (rdFill),
        .beat_idx_i  (beat_q),
        .beat_data_i (burst_rdata),
        .line_o      (pmem_rdata),
        .beat_o      (unusedRdBeat)
    );

    line_beat_buffer #(.LINE_W(LINE_W), .BURST_W(BURST_W)) u_wr_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (wrLoad),
        .line_i      (pmem_wdata),
        .beat_we_i   (1'b0),
        .beat_idx_i  (beat_q),
        .beat_data_i ({BURST_W{1'b0}}),
        .line_o      (unusedWrLine),
        .beat_o      (wrBeat)
    );

    assign pmem_resp   = resp_q;
    assign burst_read  = rd_q;
    assign burst_write = wr_q;
    assign burst_addr  = addr_q;
    assign burst_wdata = wr_q ? wrBeat : {BURST_W{1'b0}};

`ifdef CACHELINE_ADAPTOR_STATS_EN
    logic [STAT_W-1:0] reads_q, writes_q;

    // Counted on the edge that enters RESP, keyed by which burst just finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else if (lastAccept) begin
            if (rd_q) reads_q  <= reads_q + 1'b1;
            if (wr_q) writes_q <= writes_q + 1'b1;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
`endif

endmodule
